// File: rtl/lcv_mul_seq_del_if.sv
// lcv_mul_seq_del_if
//   Operand/result handshake bundle for the sequential multiplier.
//   Ports (no physical ports; signals only):
//     inp_valid/inp_ready/inp_a/inp_b/inp_signed : operand valid/ready channel
//     outp_valid/outp_ready/outp_data            : product valid/ready channel
//     busy                                       : sequencer not idle
//   Modports: master = operand producer / product consumer,
//             slave  = the multiplier sequencer.
interface lcv_mul_seq_del_if #(
  parameter int WIDTH = 32
);
  logic               inp_valid;
  logic               inp_ready;
  logic [WIDTH-1:0]   inp_a;
  logic [WIDTH-1:0]   inp_b;
  logic               inp_signed;
  logic               outp_valid;
  logic               outp_ready;
  logic [2*WIDTH-1:0] outp_data;
  logic               busy;

  modport master (
    output inp_valid, inp_a, inp_b, inp_signed, outp_ready,
    input  inp_ready, outp_valid, outp_data, busy
  );

  modport slave (
    input  inp_valid, inp_a, inp_b, inp_signed, outp_ready,
    output inp_ready, outp_valid, outp_data, busy
  );
endinterface

// File: rtl/lcv_mul_seq_del.sv
// lcv_mul_seq_del
//   Multi-cycle WIDTH x WIDTH -> 2*WIDTH multiplier (signed or unsigned)
//   built from four (HALF+1) x (HALF+1) signed partial products, issued one
//   per cycle into a single registered multiply and shift-accumulated.
//   Ports:
//     clk  : clock, rising edge
//     rst  : asynchronous active-high reset
//     bus  : lcv_mul_seq_del_if.slave
//            inp_*  operand handshake (operands/mode captured at accept)
//            outp_* product handshake (outp_data = product mod 2^(2*WIDTH))
//            busy   high in every state except IDLE
//   WIDTH must be even.
module lcv_mul_seq_del #(
  parameter int WIDTH = 32
) (
  input  logic              clk,
  input  logic              rst,
  lcv_mul_seq_del_if.slave  bus
);

  localparam int HALF = WIDTH / 2;
  localparam int PW   = WIDTH + 2;    // width of one (HALF+1)x(HALF+1) product
  localparam int AW   = 2 * WIDTH;    // accumulator / result width

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]           state_reg, state_next;
  logic                 accept;

  // Captured operands: index 0 = multiplicand (a), index 1 = multiplier (b)
  logic [WIDTH-1:0]     opnd_reg [2];
  logic                 signed_reg;
  logic [1:0]           idx_reg;

  logic signed [HALF:0] lo_ext [2];
  logic signed [HALF:0] hi_ext [2];

  logic signed [HALF:0] mul_x, mul_y;
  logic signed [PW-1:0] pp;
  logic [1:0]           pp_shift;

  logic signed [PW-1:0] prod_reg;
  logic [1:0]           prod_shift_reg;
  logic                 prod_valid_reg;

  logic [AW-1:0]        prod_ext;
  logic [AW-1:0]        addend;
  logic [AW-1:0]        acc_reg;

  // ---------------------------------------------------------------------------
  // Handshake and status
  // ---------------------------------------------------------------------------
  // Ready in DONE only when the result is being taken this same cycle, so a
  // new operation can start without a bubble through IDLE.
  assign bus.inp_ready  = (state_reg == IDLE) ||
                          ((state_reg == DONE) && bus.outp_ready);
  assign accept         = bus.inp_valid && bus.inp_ready;
  assign bus.outp_valid = (state_reg == DONE);
  assign bus.outp_data  = acc_reg;
  assign bus.busy       = (state_reg != IDLE);

  // ---------------------------------------------------------------------------
  // State sequencing
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (accept) state_next = ISSUE;
      end
      ISSUE: begin
        if (idx_reg == 2'd3) state_next = DRAIN;
      end
      DRAIN: begin
        state_next = DONE;
      end
      DONE: begin
        if (bus.outp_ready) state_next = accept ? ISSUE : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Operand capture and issue index
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      opnd_reg[0] <= '0;
      opnd_reg[1] <= '0;
      signed_reg  <= 1'b0;
      idx_reg     <= 2'd0;
    end else if (accept) begin
      opnd_reg[0] <= bus.inp_a;
      opnd_reg[1] <= bus.inp_b;
      signed_reg  <= bus.inp_signed;
      idx_reg     <= 2'd0;
    end else if (state_reg == ISSUE) begin
      // Wraps 3 -> 0 on the way into DRAIN; value is unused until next accept.
      idx_reg <= idx_reg + 2'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Operand split. The extra top bit lets one signed multiplier handle both
  // modes: low halves are always non-negative, high halves carry the operand
  // sign only in signed mode.
  // ---------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_split
      assign lo_ext[gi] = {1'b0, opnd_reg[gi][HALF-1:0]};
      assign hi_ext[gi] = {signed_reg & opnd_reg[gi][WIDTH-1],
                           opnd_reg[gi][WIDTH-1:HALF]};
    end
  endgenerate

  // idx bit 1 selects the high half of a, bit 0 the high half of b:
  //   0: aL*bL <<0   1: aL*bH <<HALF   2: aH*bL <<HALF   3: aH*bH <<2*HALF
  assign mul_x    = idx_reg[1] ? hi_ext[0] : lo_ext[0];
  assign mul_y    = idx_reg[0] ? hi_ext[1] : lo_ext[1];
  assign pp       = PW'(mul_x) * PW'(mul_y);
  // Shift code counts the high halves involved: 0, 1 or 2 units of HALF.
  assign pp_shift = {1'b0, idx_reg[1]} + {1'b0, idx_reg[0]};

  // ---------------------------------------------------------------------------
  // Registered multiply stage
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prod_reg       <= '0;
      prod_shift_reg <= 2'd0;
      prod_valid_reg <= 1'b0;
    end else begin
      prod_valid_reg <= (state_reg == ISSUE);
      if (state_reg == ISSUE) begin
        prod_reg       <= pp;
        prod_shift_reg <= pp_shift;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Shift-accumulate. Bits carried past AW are dropped, giving the product
  // modulo 2^(2*WIDTH) in both modes.
  // ---------------------------------------------------------------------------
  assign prod_ext = {{(AW-PW){prod_reg[PW-1]}}, prod_reg};

  always_comb begin
    addend = '0;
    case (prod_shift_reg)
      2'd0:    addend = prod_ext;
      2'd1:    addend = prod_ext << HALF;
      2'd2:    addend = prod_ext << (2 * HALF);
      default: addend = '0;
    endcase
  end

  // prod_valid is never set in IDLE or DONE, so the clear on accept and the
  // accumulate cannot coincide.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_reg <= '0;
    end else if (accept) begin
      acc_reg <= '0;
    end else if (prod_valid_reg) begin
      acc_reg <= acc_reg + addend;
    end
  end

endmodule

// File: tb/tb_lcv_mul_seq_del.sv
module tb_lcv_mul_seq_del;

  logic clk;
  logic rst;
  int   n_total;
  int   n_pass;
  int   n_fail;
  int   lat;
  int   inv_bad;

  lcv_mul_seq_del_if #(.WIDTH(32)) bus_if ();

  lcv_mul_seq_del #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Waits (bounded) for outp_valid; lat = clock edges after the accept edge,
  // 99 on timeout. Also counts busy&inp_ready seen outside DONE.
  task automatic wait_result(output int l);
    l = 0;
    while (l < 20) begin
      @(posedge clk); #1;
      l++;
      if (bus_if.outp_valid) break;
      if (bus_if.busy && bus_if.inp_ready) inv_bad++;
    end
    if (!bus_if.outp_valid) l = 99;
  endtask

  task automatic run_op(input string tag, input logic [31:0] a,
                        input logic [31:0] b, input logic s,
                        input logic [63:0] exp);
    bus_if.inp_a      = a;
    bus_if.inp_b      = b;
    bus_if.inp_signed = s;
    bus_if.inp_valid  = 1'b1;
    #1;
    check({tag, " inp_ready"}, 64'(bus_if.inp_ready), 64'd1);
    @(posedge clk); #1;
    bus_if.inp_valid = 1'b0;
    bus_if.inp_a     = 32'h0;
    bus_if.inp_b     = 32'h0;
    check({tag, " busy"}, 64'(bus_if.busy), 64'd1);
    check({tag, " acc_clr"}, bus_if.outp_data, 64'd0);
    wait_result(lat);
    check({tag, " latency"}, 64'(lat), 64'd5);
    check({tag, " data"}, bus_if.outp_data, exp);
    $display("op %s a=%h b=%h s=%0d -> %h", tag, a, b, s, bus_if.outp_data);
    bus_if.outp_ready = 1'b1;
    @(posedge clk); #1;
    bus_if.outp_ready = 1'b0;
    check({tag, " idle_valid"}, 64'(bus_if.outp_valid), 64'd0);
    check({tag, " idle_busy"}, 64'(bus_if.busy), 64'd0);
  endtask

  initial begin
    logic [63:0] held;
    logic [63:0] exp_prev;
    logic [63:0] exp_cur;
    logic [63:0] ea;
    logic [63:0] eb;
    logic [31:0] ra;
    logic [31:0] rb;
    logic        rs;
    logic        pending;
    int          accepts;
    int          consumed;
    int          stall;

    n_total = 0; n_pass = 0; n_fail = 0; inv_bad = 0;
    rst = 1'b1;
    bus_if.inp_valid  = 1'b0;
    bus_if.inp_a      = 32'h0;
    bus_if.inp_b      = 32'h0;
    bus_if.inp_signed = 1'b0;
    bus_if.outp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst inp_ready", 64'(bus_if.inp_ready), 64'd1);
    check("rst outp_valid", 64'(bus_if.outp_valid), 64'd0);
    check("rst outp_data", bus_if.outp_data, 64'd0);
    check("rst busy", 64'(bus_if.busy), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed corners
    run_op("u_ffxff", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 64'hFFFFFFFE00000001);
    run_op("s_8x8",   32'h80000000, 32'h80000000, 1'b1, 64'h4000000000000000);
    run_op("s_m1xm1", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 64'h0000000000000001);
    run_op("s_m2x3",  32'hFFFFFFFE, 32'h00000003, 1'b1, 64'hFFFFFFFFFFFFFFFA);
    run_op("u_m1x5",  32'hFFFFFFFF, 32'h00000005, 1'b0, 64'h00000004FFFFFFFB);
    run_op("s_m1x5",  32'hFFFFFFFF, 32'h00000005, 1'b1, 64'hFFFFFFFFFFFFFFFB);
    run_op("s_7fx7f", 32'h7FFFFFFF, 32'h7FFFFFFF, 1'b1, 64'h3FFFFFFF00000001);
    run_op("s_8x7f",  32'h80000000, 32'h7FFFFFFF, 1'b1, 64'hC000000080000000);
    run_op("u_8x2",   32'h80000000, 32'h00000002, 1'b0, 64'h0000000100000000);

    // Backpressure: hold result 10 cycles while a new op waits, then
    // consume and accept in the same cycle.
    bus_if.inp_a = 32'h1234; bus_if.inp_b = 32'h10; bus_if.inp_signed = 1'b0;
    bus_if.inp_valid = 1'b1;
    @(posedge clk); #1;
    bus_if.inp_valid = 1'b0;
    wait_result(lat);
    check("bp latency", 64'(lat), 64'd5);
    check("bp data", bus_if.outp_data, 64'h12340);
    held = bus_if.outp_data;
    bus_if.inp_a = 32'd2; bus_if.inp_b = 32'd5; bus_if.inp_signed = 1'b0;
    bus_if.inp_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("bp hold_valid", 64'(bus_if.outp_valid), 64'd1);
      check("bp hold_data", bus_if.outp_data, held);
      check("bp hold_inp_ready", 64'(bus_if.inp_ready), 64'd0);
    end
    bus_if.outp_ready = 1'b1;
    #1;
    check("bp b2b inp_ready", 64'(bus_if.inp_ready), 64'd1);
    @(posedge clk); #1;
    bus_if.outp_ready = 1'b0;
    bus_if.inp_valid  = 1'b0;
    check("bp b2b busy", 64'(bus_if.busy), 64'd1);
    check("bp b2b valid", 64'(bus_if.outp_valid), 64'd0);
    wait_result(lat);
    check("bp b2b latency", 64'(lat), 64'd5);
    check("bp b2b data", bus_if.outp_data, 64'd10);
    $display("op bp_b2b a=2 b=5 -> %h", bus_if.outp_data);
    bus_if.outp_ready = 1'b1;
    @(posedge clk); #1;
    bus_if.outp_ready = 1'b0;

    // Reset during the third ISSUE cycle
    bus_if.inp_a = 32'hFFFFFFFF; bus_if.inp_b = 32'hFFFFFFFF;
    bus_if.inp_signed = 1'b0; bus_if.inp_valid = 1'b1;
    @(posedge clk); #1;
    bus_if.inp_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst valid", 64'(bus_if.outp_valid), 64'd0);
    check("mid_rst data", bus_if.outp_data, 64'd0);
    check("mid_rst busy", 64'(bus_if.busy), 64'd0);
    check("mid_rst inp_ready", 64'(bus_if.inp_ready), 64'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (8) begin
      @(posedge clk); #1;
      check("post_rst no_valid", 64'(bus_if.outp_valid), 64'd0);
    end
    run_op("r_7x9", 32'd7, 32'd9, 1'b0, 64'd63);

    // Random operands, random stalls, back-to-back handoff into ISSUE
    pending = 1'b0; accepts = 0; consumed = 0; exp_prev = '0;
    for (int i = 0; i < 200; i++) begin
      ra = $urandom; rb = $urandom; rs = 1'($urandom_range(0, 1));
      if (i % 16 == 0) begin ra = 32'h80000000; rb = 32'hFFFFFFFF; end
      ea = rs ? {{32{ra[31]}}, ra} : {32'h0, ra};
      eb = rs ? {{32{rb[31]}}, rb} : {32'h0, rb};
      exp_cur = ea * eb;
      bus_if.inp_a = ra; bus_if.inp_b = rb; bus_if.inp_signed = rs;
      bus_if.inp_valid = 1'b1;
      if (pending) begin
        stall = $urandom_range(0, 3);
        for (int k = 0; k < stall; k++) begin
          @(posedge clk); #1;
          check("rnd stall_valid", 64'(bus_if.outp_valid), 64'd1);
          check("rnd stall_inp_ready", 64'(bus_if.inp_ready), 64'd0);
        end
        check("rnd data", bus_if.outp_data, exp_prev);
        bus_if.outp_ready = 1'b1;
      end
      #1;
      check("rnd inp_ready", 64'(bus_if.inp_ready), 64'd1);
      @(posedge clk); #1;
      if (pending) consumed++;
      accepts++;
      bus_if.inp_valid = 1'b0;
      bus_if.outp_ready = 1'b0;
      wait_result(lat);
      check("rnd latency", 64'(lat), 64'd5);
      pending = 1'b1;
      exp_prev = exp_cur;
    end
    check("rnd last_data", bus_if.outp_data, exp_prev);
    bus_if.outp_ready = 1'b1;
    @(posedge clk); #1;
    bus_if.outp_ready = 1'b0;
    consumed++;
    check("rnd handshakes", 64'(consumed), 64'(accepts));
    check("rnd final_idle", 64'(bus_if.busy), 64'd0);
    check("busy_ready_invariant", 64'(inv_bad), 64'd0);
    $display("random ops accepted=%0d consumed=%0d", accepts, consumed);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
